// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register-fetch storage with a per-register pending-write scoreboard.
// Register 0 reads as zero; LO/HI sit at NUM_REGS-2 / NUM_REGS-1 and are written only
// through hilo_we. General registers 1..NUM_REGS-3 carry a saturating pending counter.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writeback data to reads.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned MAX_PEND = 5,
    parameter int unsigned AW       = $clog2(NUM_REGS),
    parameter int unsigned CW       = $clog2(MAX_PEND + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     claim_valid,
    input  logic [AW-1:0]            claim_addr,
    output logic                     claim_ready,
    input  logic                     wb_valid,
    input  logic [AW-1:0]            wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     hilo_we,
    input  logic [DATA_W-1:0]        lo_data,
    input  logic [DATA_W-1:0]        hi_data,
    output logic                     err_underflow
);

    // Arrays cover the full address space so every address indexes in range;
    // entries at or above NUM_REGS are never written and stay zero.
    localparam int unsigned NUM_ENT = 1 << AW;
    localparam int unsigned LO_IDX  = NUM_REGS - 2;
    localparam int unsigned HI_IDX  = NUM_REGS - 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PEND);

    logic [DATA_W-1:0] regs_q [NUM_ENT];
    logic [DATA_W-1:0] regs_d [NUM_ENT];
    logic [CW-1:0]     cnt_q  [NUM_ENT];
    logic [CW-1:0]     cnt_d  [NUM_ENT];
    logic              err_q;
    logic              err_d;

    logic claim_acc;
    logic wb_act;
    logic same_reg;

    // True only for scoreboarded registers (excludes zero, LO, HI and unused addresses).
    function automatic logic is_gen(input logic [AW-1:0] a);
        return (a != '0) && (32'(a) < NUM_REGS - 2);
    endfunction

    // claim_ready looks at claim_addr and the stored count only.
    assign claim_ready = !(is_gen(claim_addr) && (cnt_q[claim_addr] == MAX_CNT));
    assign claim_acc   = claim_valid && claim_ready && is_gen(claim_addr);
    assign wb_act      = wb_valid && is_gen(wb_addr);
    assign same_reg    = claim_acc && wb_act && (claim_addr == wb_addr);

    assign err_underflow = err_q;

    // Next-state for data, pending counters and the sticky underflow flag.
    always_comb begin
        for (int unsigned i = 0; i < NUM_ENT; i++) begin
            regs_d[i] = regs_q[i];
            cnt_d[i]  = cnt_q[i];
            if (wb_act && (wb_addr == AW'(i))) begin
                regs_d[i] = wb_data;
            end
            if (claim_acc && (claim_addr == AW'(i)) && !(wb_act && (wb_addr == AW'(i)))) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (wb_act && (wb_addr == AW'(i)) &&
                         !(claim_acc && (claim_addr == AW'(i))) && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
        if (hilo_we) begin
            regs_d[LO_IDX] = lo_data;
            regs_d[HI_IDX] = hi_data;
        end
        // A matching same-cycle claim covers the writeback, so no underflow then.
        err_d = err_q | (wb_act && (cnt_q[wb_addr] == '0) && !same_reg);
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ENT; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_ENT; i++) begin
                regs_q[i] <= regs_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            err_q <= err_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign addr = rd_addr[p*AW +: AW];

        // Combinational operand read with busy status.
        always_comb begin
            data = regs_q[addr];
            busy = (cnt_q[addr] != '0);
`ifdef REGFILE_BYPASS_EN
            // Forwarded read reports the count the register will hold after the edge.
            if (wb_act && (wb_addr == addr)) begin
                data = wb_data;
                busy = (cnt_d[addr] != '0);
            end
`endif
        end

        assign rd_data[p*DATA_W +: DATA_W] = data;
        assign rd_busy[p]                  = busy;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: a vector table of per-cycle stimulus with
// hand-derived expected outputs, checked through a scoreboard queue, plus a hand-written
// mid-operation reset sequence.
module tb_regfile_scoreboard;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned ND = 2;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [ND*AW-1:0]  rd_addr;
    logic [ND*DW-1:0]  rd_data;
    logic [ND-1:0]     rd_busy;
    logic              claim_valid;
    logic [AW-1:0]     claim_addr;
    logic              claim_ready;
    logic              wb_valid;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;
    logic              hilo_we;
    logic [DW-1:0]     lo_data;
    logic [DW-1:0]     hi_data;
    logic              err_underflow;

    regfile_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_busy       (rd_busy),
        .claim_valid   (claim_valid),
        .claim_addr    (claim_addr),
        .claim_ready   (claim_ready),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .hilo_we       (hilo_we),
        .lo_data       (lo_data),
        .hi_data       (hi_data),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cv;
        logic [4:0]  ca;
        logic        wv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        hw;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic [1:0]  eb;
        logic        er;
        logic        ee;
    } vec_t;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  b;
        logic        r;
        logic        e;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic cv, input logic [4:0] ca, input logic wv,
                                input logic [4:0] wa, input logic [31:0] wd, input logic hw,
                                input logic [31:0] lo, input logic [31:0] hi,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] ed0, input logic [31:0] ed1,
                                input logic [1:0] eb, input logic er, input logic ee);
        vec_t v;
        v.cv = cv;   v.ca = ca;   v.wv = wv;   v.wa = wa;   v.wd = wd;
        v.hw = hw;   v.lo = lo;   v.hi = hi;   v.ra0 = ra0; v.ra1 = ra1;
        v.ed0 = ed0; v.ed1 = ed1; v.eb = eb;   v.er = er;   v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        claim_valid = v.cv;
        claim_addr  = v.ca;
        wb_valid    = v.wv;
        wb_addr     = v.wa;
        wb_data     = v.wd;
        hilo_we     = v.hw;
        lo_data     = v.lo;
        hi_data     = v.hi;
        rd_addr     = {v.ra1, v.ra0};
    endtask

    task automatic push_exp(input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] b,
                            input logic r, input logic e);
        exp_t x;
        x.d0 = d0; x.d1 = d1; x.b = b; x.r = r; x.e = e;
        sb.push_back(x);
    endtask

    // Pops the oldest expectation and compares it with the current DUT outputs.
    task automatic compare_out(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
            return;
        end
        x = sb.pop_front();
        chk({tag, ".rd_data0"}, rd_data[31:0], x.d0);
        chk({tag, ".rd_data1"}, rd_data[63:32], x.d1);
        chk({tag, ".rd_busy"}, 32'(rd_busy), 32'(x.b));
        chk({tag, ".claim_ready"}, 32'(claim_ready), 32'(x.r));
        chk({tag, ".err_underflow"}, 32'(err_underflow), 32'(x.e));
    endtask

    initial begin
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 2'b00, 1, 0));

        // Vector table: inputs for one cycle and the outputs expected before that edge.
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 1, 0));
        // Saturation on r7.
        vecs.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, 7, 7, 0, 0, 2'b00, 1, 0));
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, 7, 7, 0, 0, 2'b11, 1, 0));
        end
        vecs.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, 7, 7, 0, 0, 2'b11, 0, 0));
        vecs.push_back(mk(0, 7, 1, 7, 32'h77, 0, 0, 0, 7, 7,
                          BYP ? 32'h77 : 32'h0, BYP ? 32'h77 : 32'h0, 2'b11, 0, 0));
        vecs.push_back(mk(0, 7, 0, 0, 0, 0, 0, 0, 7, 7, 32'h77, 32'h77, 2'b11, 1, 0));
        // Same-cycle claim and writeback on r3 with count 2.
        vecs.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0, 2'b00, 1, 0));
        vecs.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0, 2'b11, 1, 0));
        vecs.push_back(mk(1, 3, 1, 3, 32'hDEADBEEF, 0, 0, 0, 3, 7,
                          BYP ? 32'hDEADBEEF : 32'h0, 32'h77, 2'b11, 1, 0));
        vecs.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 3, 3, 32'hDEADBEEF, 32'hDEADBEEF,
                          2'b11, 1, 0));
        // Same-cycle claim and writeback on r12 at count 0: no error.
        vecs.push_back(mk(1, 12, 1, 12, 32'hC0, 0, 0, 0, 12, 3,
                          BYP ? 32'hC0 : 32'h0, 32'hDEADBEEF, 2'b10, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 12, 12, 32'hC0, 32'hC0, 2'b00, 1, 0));
        // Underflow on r9.
        vecs.push_back(mk(0, 0, 1, 9, 32'h1234, 0, 0, 0, 9, 3,
                          BYP ? 32'h1234 : 32'h0, 32'hDEADBEEF, 2'b10, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 32'h1234, 0, 2'b00, 1, 1));
        // Zero register and LO/HI.
        vecs.push_back(mk(0, 0, 1, 0, 32'hFFFF, 1, 32'h11, 32'h22, 0, 30, 0, 0, 2'b00, 1, 1));
        vecs.push_back(mk(1, 30, 1, 31, 32'h99, 0, 0, 0, 30, 31, 32'h11, 32'h22, 2'b00, 1, 1));
        vecs.push_back(mk(0, 31, 0, 0, 0, 0, 0, 0, 0, 31, 0, 32'h22, 2'b00, 1, 1));
        // Writeback to r4 while its count is 1 and port 1 reads it.
        vecs.push_back(mk(1, 4, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 2'b00, 1, 1));
        vecs.push_back(mk(0, 0, 1, 4, 32'hA5A5, 0, 0, 0, 1, 4,
                          0, BYP ? 32'hA5A5 : 32'h0, BYP ? 2'b00 : 2'b10, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 4, 32'hA5A5, 32'hA5A5, 2'b00, 1, 1));
        // Claim r10 and writeback r7 in the same cycle.
        vecs.push_back(mk(1, 10, 1, 7, 32'h700, 0, 0, 0, 10, 7,
                          0, BYP ? 32'h700 : 32'h77, 2'b10, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 10, 7, 0, 32'h700, 2'b11, 1, 1));

        // Outputs while reset is held.
        repeat (2) @(negedge clk);
        push_exp(0, 0, 2'b00, 1, 0);
        #1;
        compare_out("in_reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            push_exp(vecs[i].ed0, vecs[i].ed1, vecs[i].eb, vecs[i].er, vecs[i].ee);
            #1;
            compare_out($sformatf("row%0d", i));
            @(negedge clk);
        end

        // Reset mid-operation: r5 claimed three times and written, then reset between edges.
        for (int i = 0; i < 3; i++) begin
            drive(mk(1, 5, 0, 0, 0, 0, 0, 0, 5, 5, 0, 0, 0, 0, 0));
            @(negedge clk);
        end
        drive(mk(1, 5, 1, 5, 32'h55, 0, 0, 0, 5, 5, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk(0, 5, 0, 0, 0, 0, 0, 0, 5, 5, 0, 0, 0, 0, 0));
        push_exp(32'h55, 32'h55, 2'b11, 1, 1);
        #1;
        compare_out("pre_reset");
        #2;
        rst = 1'b1;
        push_exp(0, 0, 2'b00, 1, 0);
        #1;
        compare_out("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        drive(mk(1, 5, 0, 0, 0, 0, 0, 0, 3, 30, 0, 0, 0, 0, 0));
        push_exp(0, 0, 2'b00, 1, 0);
        #1;
        compare_out("post_reset");
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 7, 0, 0, 0, 0, 0));
        push_exp(0, 0, 2'b01, 1, 0);
        #1;
        compare_out("post_reset_claim");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
